keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad and delivers one debounced 4-bit key code per press, ready to drive the 4-bit value input of the seven-segment display controller. The display controller multiplexes outputs by strobing one anode at a time. This block does the opposite on the input side: it strobes one keypad row at a time and reads the column lines back. It sits between the board's Pmod keypad pins and the user logic.

## Interface
- SCAN_DIV, default 100000, clock cycles each row is driven per scan step; one "tick" per period. Must be ≥ 3.
- DEBOUNCE_SCANS, default 10, number of consecutive agreeing ticks required to accept a press or a release. Must be ≥ 1.
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- col_in  input  4  keypad column lines, active-low (pulled up off-chip), asynchronous to clk.
- row_out  output  4  keypad row drive, active-low one-hot.
- key_code  output  4  code of the last accepted key; holds its value until the next accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high from acceptance until the release is debounced.

## Operation
- col_in passes through a 2-flop synchronizer. All decisions use the synchronized value `cs`.
- Divider counts 0..SCAN_DIV-1 and wraps. A tick is the cycle with count = SCAN_DIV-1. The divider free-runs in every state.
- Key map, as row r/col c → code:
  - r0: 1, 2, 3, A → 0x1, 0x2, 0x3, 0xA
  - r1: 4, 5, 6, B → 0x4, 0x5, 0x6, 0xB
  - r2: 7, 8, 9, C → 0x7, 0x8, 0x9, 0xC
  - r3: *, 0, #, D → 0xE, 0x0, 0xF, 0xD
- A sample is "single" when exactly one bit of `cs` is 0. Zero or multiple low bits count as "none".
- FSM states:
  - SCAN: drive row r. At a tick:
    - single on column c: latch candidate (r, c), hold row r, go to DEBOUNCE with agree-count = 0.
    - none: advance r (0→1→2→3→0).
  - DEBOUNCE: row held. At each tick:
    - single on the same c: agree-count +1. When it reaches DEBOUNCE_SCANS, load key_code from the map, pulse key_valid, set key_held, and go to HELD.
    - anything else: discard the candidate, advance r, go to SCAN.
  - HELD: row held. At each tick:
    - `cs` = 4'b1111: release-count +1.
    - otherwise: release-count cleared.
    - When release-count reaches DEBOUNCE_SCANS: clear key_held, advance r, go to SCAN.
    - Additional keys pressed while in HELD are ignored; no second key_valid is issued.
- Counters are sized to hold DEBOUNCE_SCANS and SCAN_DIV-1 without overflow.

## Timing
- Reset values: row_out = 4'b1110 (row 0), key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, divider = 0, all counts 0, synchronizer flops = 4'b1111.
- rst asserted in any state restores all reset values at the next clk edge. A pending candidate is discarded, and no key_valid is issued during or after reset.
- row_out changes only in the cycle after a tick, so every row is driven for exactly SCAN_DIV cycles during SCAN.
- Acceptance latency: press detected at tick T0 → key_valid high in the cycle after tick T0 + DEBOUNCE_SCANS·SCAN_DIV cycles. key_code and key_held update in the same cycle as key_valid.
- key_valid is exactly one cycle wide, and there is at most one pulse per press–release cycle.
- Release latency: first all-high tick T1 → key_held low in the cycle after tick T1 + (DEBOUNCE_SCANS-1)·SCAN_DIV cycles, provided no bounce.
- A column change settles through the synchronizer 2 cycles after it occurs. SCAN_DIV ≥ 3 guarantees the tick samples settled data for the current row.

## Test plan
Bench settings: SCAN_DIV = 4, DEBOUNCE_SCANS = 3. Keypad model drives col c low while row_out[r] = 0 for each pressed (r, c).
1. Reset then idle 100 cycles with no key → row_out cycles 1110→1101→1011→0111→1110, each held 4 cycles; key_valid never 1; key_code = 0.
2. Hold '5' (r1, c1) steady → exactly one key_valid pulse, 12 cycles after the detecting tick; key_code = 0x5; key_held = 1; row_out held at 1101. Release → key_held = 0 after 3 all-high ticks, and scanning resumes at row 2.
3. Press '#' (r3, c2) with 2 bounces (col toggles at ticks 1–2 of DEBOUNCE) and then stable → no pulse during the bounce; a single later pulse with key_code = 0xF.
4. While holding 'A', also press '7' → a single pulse with key_code = 0xA; no pulse for '7' until 'A' is released and '7' is rescanned (code 0x7).
5. Press '1' and '2' together (r0, c0 + c1) → no key_valid; scanning continues.
6. Assert rst at agree-count = 2 in DEBOUNCE → next cycle shows row_out = 1110, key_held = 0, no key_valid. After release of rst with the key still held, a full fresh debounce is required before the pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low row at a time, reads the
// column lines back and delivers one debounced 4-bit key code per press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [3:0]       sync_reg;
    logic [3:0]       cs_reg;
    logic [DIV_W-1:0] div_reg;
    logic             tick;

    state_t           state_reg;
    logic [1:0]       row_reg;
    logic [1:0]       cand_reg;
    logic [DB_W-1:0]  agree_reg;
    logic [DB_W-1:0]  release_reg;
    logic [3:0]       row_out_reg;
    logic [3:0]       key_code_reg;
    logic             key_valid_reg;
    logic             key_held_reg;

    logic [3:0]       col_match;
    logic             single;
    logic [1:0]       col_idx;
    logic [1:0]       row_adv;
    logic [3:0]       row_adv_drive;
    logic [DB_W-1:0]  agree_inc;
    logic [DB_W-1:0]  release_inc;

    // Two-flop synchronizer; idles at all-high so reset looks like "no key".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 4'b1111;
            cs_reg   <= 4'b1111;
        end else begin
            sync_reg <= col_in;
            cs_reg   <= sync_reg;
        end
    end

    // Free-running scan divider, independent of the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick = (div_reg == DIV_LAST);

    // A column matches only when it is the sole low line.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_match[gi] = (cs_reg == ~(4'b0001 << gi));
        end
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_adv_drive[gi] = (row_adv != 2'(gi));
        end
    endgenerate

    assign single = |col_match;

    always_comb begin
        col_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (col_match[i]) begin
                col_idx = 2'(i);
            end
        end
    end

    assign row_adv     = row_reg + 2'd1;
    assign agree_inc   = agree_reg + 1'b1;
    assign release_inc = release_reg + 1'b1;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Scan / debounce / held FSM; every decision is taken on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN;
            row_reg       <= 2'd0;
            cand_reg      <= 2'd0;
            agree_reg     <= '0;
            release_reg   <= '0;
            row_out_reg   <= 4'b1110;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            if (tick) begin
                case (state_reg)
                    SCAN: begin
                        if (single) begin
                            cand_reg  <= col_idx;
                            agree_reg <= '0;
                            state_reg <= DEBOUNCE;
                        end else begin
                            row_reg     <= row_adv;
                            row_out_reg <= row_adv_drive;
                        end
                    end
                    DEBOUNCE: begin
                        if (single && (col_idx == cand_reg)) begin
                            agree_reg <= agree_inc;
                            if (agree_inc == DB_DONE) begin
                                key_code_reg  <= key_lookup(row_reg, cand_reg);
                                key_valid_reg <= 1'b1;
                                key_held_reg  <= 1'b1;
                                release_reg   <= '0;
                                state_reg     <= HELD;
                            end
                        end else begin
                            row_reg     <= row_adv;
                            row_out_reg <= row_adv_drive;
                            state_reg   <= SCAN;
                        end
                    end
                    HELD: begin
                        // Any low column on the held row restarts the release count.
                        if (cs_reg == 4'b1111) begin
                            if (release_inc == DB_DONE) begin
                                release_reg  <= '0;
                                key_held_reg <= 1'b0;
                                row_reg      <= row_adv;
                                row_out_reg  <= row_adv_drive;
                                state_reg    <= SCAN;
                            end else begin
                                release_reg <= release_inc;
                            end
                        end else begin
                            release_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= SCAN;
                    end
                endcase
            end
        end
    end

    assign row_out   = row_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// columns and a tick-level behavioural model predicts every output cycle.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;
    int checks = 0;
    int passed = 0;
    int cyc = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    int         m_div, m_row, m_mode, m_cand, m_streak, m_quiet;
    int         m_detect_cyc = 0;
    bit         m_valid, m_held;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    // Reference: at each scan period boundary look at the keys on the driven row.
    always @(posedge clk) begin
        logic [3:0] seen;
        int n;
        cyc = cyc + 1;
        if (rst) begin
            m_div = 0; m_row = 0; m_mode = 0; m_cand = 0; m_streak = 0; m_quiet = 0;
            m_valid = 0; m_held = 0; m_code = 4'h0;
        end else begin
            m_valid = 0;
            if (m_div == SD - 1) begin
                m_div = 0;
                seen  = pressed[m_row*4 +: 4];
                n     = $countones(seen);
                if (m_mode == 0) begin
                    if (n == 1) begin
                        for (int c = 0; c < 4; c++) if (seen[c]) m_cand = c;
                        m_mode = 1; m_streak = 0; m_detect_cyc = cyc;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else if (m_mode == 1) begin
                    if (n == 1 && seen[m_cand]) begin
                        m_streak = m_streak + 1;
                        if (m_streak == DS) begin
                            m_code = kmap[m_row*4 + m_cand];
                            m_valid = 1; m_held = 1; m_mode = 2; m_quiet = 0;
                        end
                    end else begin
                        m_mode = 0;
                        m_row = (m_row + 1) % 4;
                    end
                end else begin
                    m_quiet = (n == 0) ? m_quiet + 1 : 0;
                    if (m_quiet == DS) begin
                        m_held = 0; m_mode = 0;
                        m_row = (m_row + 1) % 4;
                    end
                end
            end else begin
                m_div = m_div + 1;
            end
        end
    end

    function automatic logic [9:0] model_out();
        logic [3:0] er;
        er = 4'hF;
        er[m_row] = 1'b0;
        return {er, m_code, m_valid, m_held};
    endfunction

    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1;
        pressed = '0;
        repeat (3) @(negedge clk);
        obs = {row_out, key_code, key_valid, key_held};
        checks++;
        if (obs !== 10'b1110_0000_0_0) $display("FAIL reset_state got=%b exp=%b", obs, 10'b1110_0000_0_0);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        obs = {row_out, key_code, key_valid, key_held};
        checks++;
        if (obs !== 10'b1110_0000_0_0) $display("FAIL reset_release got=%b exp=%b", obs, 10'b1110_0000_0_0);
        else passed++;
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_idle();
        logic [9:0] obs, exp_v;
        int pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL idle cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL idle_pulses got=%0d exp=0", pulses);
        else passed++;
        $display("idle: 100 cycles, pulses=%0d", pulses);
    endtask

    task automatic test_single_key(input int idx, input string tag);
        logic [9:0] obs, exp_v;
        logic [3:0] er;
        int phase = 0, hold = 0, pulses = 0, hold_len;
        hold_len = 4 + int'($urandom_range(0, 12));
        for (int k = 0; k < 400 && phase < 5; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) pulses++;
            case (phase)
                0: if (m_div == 0) begin pressed[idx] = 1'b1; phase = 1; end
                1: if (key_valid === 1'b1) begin
                    checks++;
                    if (cyc - m_detect_cyc != SD*DS)
                        $display("FAIL %s latency got=%0d exp=%0d", tag, cyc - m_detect_cyc, SD*DS);
                    else passed++;
                    checks++;
                    if (key_code !== kmap[idx]) $display("FAIL %s code got=%h exp=%h", tag, key_code, kmap[idx]);
                    else passed++;
                    phase = 2;
                end
                2: begin
                    hold++;
                    if (hold >= hold_len && m_div == 0) begin pressed[idx] = 1'b0; phase = 3; end
                end
                3: if (key_held === 1'b0) begin
                    er = 4'hF;
                    er[(idx/4 + 1) % 4] = 1'b0;
                    checks++;
                    if (row_out !== er) $display("FAIL %s row_after_release got=%b exp=%b", tag, row_out, er);
                    else passed++;
                    phase = 4; hold = 0;
                end
                default: begin hold++; if (hold >= 6) phase = 5; end
            endcase
        end
        checks++;
        if (phase < 5) $display("FAIL %s timeout phase got=%0d exp=5", tag, phase);
        else passed++;
        checks++;
        if (pulses != 1) $display("FAIL %s pulses got=%0d exp=1", tag, pulses);
        else passed++;
        $display("%s: key idx=%0d code=%h pulses=%0d", tag, idx, kmap[idx], pulses);
    endtask

    task automatic test_bounce();
        logic [9:0] obs, exp_v;
        int phase = 0, hold = 0, pulses = 0, early = 0;
        for (int k = 0; k < 400 && phase < 6; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) begin pulses++; if (phase < 3) early++; end
            case (phase)
                0: if (m_div == 0) begin pressed[14] = 1'b1; phase = 1; end
                1: if (m_mode == 1 && m_streak == 0 && m_div == 0) begin pressed[14] = 1'b0; phase = 2; end
                2: if (m_div == 0) begin pressed[14] = 1'b1; phase = 3; end
                3: if (key_valid === 1'b1) begin
                    checks++;
                    if (key_code !== 4'hF) $display("FAIL bounce code got=%h exp=f", key_code);
                    else passed++;
                    phase = 4;
                end
                4: begin hold++; if (hold >= 8 && m_div == 0) begin pressed[14] = 1'b0; phase = 5; end end
                default: if (key_held === 1'b0) phase = 6;
            endcase
        end
        checks++;
        if (phase < 6) $display("FAIL bounce timeout phase got=%0d exp=6", phase);
        else passed++;
        checks++;
        if (pulses != 1 || early != 0) $display("FAIL bounce pulses got=%0d early=%0d exp=1 early=0", pulses, early);
        else passed++;
        $display("bounce: key '#' pulses=%0d", pulses);
    endtask

    task automatic test_held_ignore();
        logic [9:0] obs, exp_v;
        int phase = 0, hold = 0, pulses = 0, window = 0;
        for (int k = 0; k < 600 && phase < 7; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL held_ignore cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) begin pulses++; if (phase == 3) window++; end
            case (phase)
                0: if (m_div == 0) begin pressed[3] = 1'b1; phase = 1; end
                1: if (key_valid === 1'b1) begin
                    checks++;
                    if (key_code !== 4'hA) $display("FAIL held_ignore code_a got=%h exp=a", key_code);
                    else passed++;
                    phase = 2; hold = 0;
                end
                2: begin hold++; if (hold > 2 && m_div == 0) begin pressed[8] = 1'b1; phase = 3; hold = 0; end end
                3: begin hold++; if (hold >= 24 && m_div == 0) begin pressed[3] = 1'b0; phase = 4; end end
                4: if (key_valid === 1'b1) begin
                    checks++;
                    if (key_code !== 4'h7) $display("FAIL held_ignore code_7 got=%h exp=7", key_code);
                    else passed++;
                    phase = 5; hold = 0;
                end
                5: begin hold++; if (hold >= 6 && m_div == 0) begin pressed[8] = 1'b0; phase = 6; end end
                default: if (key_held === 1'b0) phase = 7;
            endcase
        end
        checks++;
        if (phase < 7) $display("FAIL held_ignore timeout phase got=%0d exp=7", phase);
        else passed++;
        checks++;
        if (pulses != 2 || window != 0) $display("FAIL held_ignore pulses got=%0d window=%0d exp=2 window=0", pulses, window);
        else passed++;
        $display("held_ignore: 'A' then '7', pulses=%0d", pulses);
    endtask

    task automatic test_multi_key();
        logic [9:0] obs, exp_v;
        logic [3:0] last_row;
        int pulses = 0, changes = 0;
        @(negedge clk);
        while (m_div != 0) @(negedge clk);
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        last_row = row_out;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL multi_key cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) pulses++;
            if (row_out !== last_row) changes++;
            last_row = row_out;
        end
        pressed = '0;
        checks++;
        if (pulses != 0 || changes < 18) $display("FAIL multi_key pulses got=%0d changes=%0d exp=0 changes>=18", pulses, changes);
        else passed++;
        $display("multi_key: '1'+'2' pulses=%0d row_changes=%0d", pulses, changes);
    endtask

    task automatic test_reset_mid(input int idx);
        logic [9:0] obs, exp_v;
        int phase = 0, hold = 0, pulses = 0, early = 0, rel_cyc = 0;
        for (int k = 0; k < 500 && phase < 6; k++) begin
            @(negedge clk);
            obs = {row_out, key_code, key_valid, key_held};
            exp_v = model_out();
            checks++;
            if (obs !== exp_v) $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
            else passed++;
            if (key_valid === 1'b1) begin pulses++; if (phase < 3) early++; end
            case (phase)
                0: if (m_div == 0) begin pressed[idx] = 1'b1; phase = 1; end
                1: if (m_mode == 1 && m_streak == 2) begin rst = 1'b1; phase = 2; hold = 0; end
                2: begin
                    hold++;
                    if (hold == 1) begin
                        checks++;
                        if ({row_out, key_valid, key_held} !== 6'b1110_0_0)
                            $display("FAIL reset_mid in_reset got=%b exp=%b", {row_out, key_valid, key_held}, 6'b1110_0_0);
                        else passed++;
                    end
                    if (hold == 3) begin rst = 1'b0; rel_cyc = cyc; phase = 3; end
                end
                3: if (key_valid === 1'b1) begin
                    checks++;
                    if (m_detect_cyc <= rel_cyc || cyc - m_detect_cyc != SD*DS)
                        $display("FAIL reset_mid fresh_debounce got=%0d exp=%0d", cyc - rel_cyc, SD*DS);
                    else passed++;
                    phase = 4; hold = 0;
                end
                4: begin hold++; if (hold >= 6 && m_div == 0) begin pressed[idx] = 1'b0; phase = 5; end end
                default: if (key_held === 1'b0) phase = 6;
            endcase
        end
        checks++;
        if (phase < 6) $display("FAIL reset_mid timeout phase got=%0d exp=6", phase);
        else passed++;
        checks++;
        if (pulses != 1 || early != 0) $display("FAIL reset_mid pulses got=%0d early=%0d exp=1 early=0", pulses, early);
        else passed++;
        $display("reset_mid: key idx=%0d pulses=%0d", idx, pulses);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_key(5, "key_5");
        for (int i = 0; i < 6; i++) test_single_key(int'($urandom_range(0, 15)), "rand_key");
        test_bounce();
        test_held_ignore();
        test_multi_key();
        test_reset_mid(int'($urandom_range(0, 15)));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
